// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial carry-lookahead adder:
//   - CLA_NIB_W : width of one lookahead slice (4 bits)
//   - cla_state_t : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - clog2()   : index width helper, never narrower than one bit
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  // Width needed to count 0..value-1. A single-nibble adder still gets a
  // one-bit index so that no zero-width vector is ever declared.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// -----------------------------------------------------------------------------
// cla_nibble_slice
// Purely combinational 4-bit carry-lookahead slice.
// Ports:
//   a, b   in  [3:0]  operand nibbles
//   cin    in         carry into bit 0 of the nibble
//   s      out [3:0]  nibble sum
//   c3     out        carry into bit 3 (used for signed overflow)
//   c4     out        carry out of bit 3
//   g_grp  out        group generate
//   p_grp  out        group propagate
// -----------------------------------------------------------------------------
module cla_nibble_slice
  import cla_pkg::*;
(
  input  logic [CLA_NIB_W-1:0] a,
  input  logic [CLA_NIB_W-1:0] b,
  input  logic                 cin,
  output logic [CLA_NIB_W-1:0] s,
  output logic                 c3,
  output logic                 c4,
  output logic                 g_grp,
  output logic                 p_grp
);

  logic [CLA_NIB_W-1:0] g;
  logic [CLA_NIB_W-1:0] p;
  logic                 c1;
  logic                 c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/cin: no ripple inside.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign p_grp = &p;
  assign c4    = g_grp | (p_grp & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_nibble_serial_adder
// Multi-cycle WIDTH-bit adder built around a single 4-bit lookahead slice.
// One nibble is processed per clock, LSB nibble first; the slice carry-out is
// held in a register and fed back as the next nibble's carry-in.
//
// Parameters:
//   WIDTH  operand/sum width, multiple of 4 and >= 4
//
// Ports:
//   clk        in            rising-edge clock
//   rst_n      in            asynchronous active-low reset
//   in_valid   in            operands present
//   in_ready   out           adder idle, operands accepted on in_valid
//   a, b       in  [WIDTH]   operands
//   cin        in            carry into bit 0
//   sub        in            subtract request (CLA_SUB_EN builds only)
//   out_valid  out           result valid, held until out_ready
//   out_ready  in            consumer takes the result
//   sum        out [WIDTH]   result, modulo 2^WIDTH
//   cout       out           carry out of bit WIDTH-1 (1 = no borrow on sub)
//   ovf        out           signed overflow
//
// Build option:
//   CLA_SUB_EN  adds the sub port; sub=1 computes a-b as a + ~b + 1.
//
// Latency: out_valid rises WIDTH/4 cycles after the accepting edge.
// -----------------------------------------------------------------------------
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / CLA_NIB_W;
  localparam int IDX_W = clog2(NIB);

  generate
    if ((WIDTH % CLA_NIB_W) != 0 || WIDTH < CLA_NIB_W) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  cla_state_t           state_q;
  cla_state_t           state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 carry_q;
  logic                 last_nib;
  logic                 accept;

  logic [WIDTH-1:0]     eff_b;
  logic                 eff_cin;

  logic [CLA_NIB_W-1:0] nib_a;
  logic [CLA_NIB_W-1:0] nib_b;
  logic [CLA_NIB_W-1:0] nib_s;
  logic                 nib_c3;
  logic                 nib_c4;
  logic                 nib_g;
  logic                 nib_p;

  // Subtraction is folded into the operand latch: a - b == a + ~b + 1.
`ifdef CLA_SUB_EN
  assign eff_b   = sub ? ~b : b;
  assign eff_cin = sub | cin;
`else
  assign eff_b   = b;
  assign eff_cin = cin;
`endif

  assign nib_a    = a_q[int'(idx_q)*CLA_NIB_W +: CLA_NIB_W];
  assign nib_b    = b_q[int'(idx_q)*CLA_NIB_W +: CLA_NIB_W];
  assign last_nib = (idx_q == IDX_W'(NIB - 1));
  assign accept   = (state_q == IDLE) && in_valid;

  cla_nibble_slice u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .s     (nib_s),
    .c3    (nib_c3),
    .c4    (nib_c4),
    .g_grp (nib_g),
    .p_grp (nib_p)
  );

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset along with the result so the slice
      // never sees X after reset; an aborted operation leaves nothing behind.
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= eff_b;
      carry_q <= eff_cin;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state_q == RUN) begin
      sum[int'(idx_q)*CLA_NIB_W +: CLA_NIB_W] <= nib_s;
      // Group generate/propagate give the slice carry-out directly, the same
      // term a second-level lookahead would consume.
      carry_q <= nib_g | (nib_p & carry_q);
      idx_q   <= idx_q + IDX_W'(1);
      if (last_nib) begin
        cout <= nib_c4;
        ovf  <= nib_c3 ^ nib_c4;
      end
    end
  end

endmodule

// File: doc/cla_nibble_serial_adder.md
Name: cla_nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that feeds one 4-bit carry-lookahead slice per clock and consumes the slice's carry-out (C4) through a registered carry.
- Processes one nibble per cycle, LSB nibble first.
- Valid/ready handshakes on both input and output.
- Sits downstream of operand registers and upstream of the result writeback, for area-constrained datapaths that trade latency for one CLA slice.

Parameters:
WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to bit 0
sub  input  1  subtract request (present only with CLA_SUB_EN)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, state=IDLE, nibble index=0, carry reg=0.
- NIB = WIDTH/4.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch a, b and cin; clear sum; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, nibble idx of a/b plus the carry reg drive the slice.
  - Per bit: gi=ai&bi, pi=ai^bi.
  - Slice carries: C1=g0|p0c, C2, C3, C4 (standard lookahead); s=p^{C3,C2,C1,c}.
  - sum[4idx+3:4idx]<=s; carry<=C4; idx<=idx+1.
  - At idx==NIB-1: cout<=C4; ovf<=C3^C4 of that nibble; out_valid<=1; go to DONE.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (4 cycles for WIDTH=16).
- DONE:
  - out_valid=1; sum, cout and ovf held stable; in_ready=0.
  - On out_ready at an edge: out_valid<=0; go to IDLE.
  - No back-to-back overlap: the next accept is possible one cycle after the result handshake at the earliest.
- in_valid while in RUN/DONE is ignored; inputs are not re-sampled.
- Wrap-around: sum is modulo 2^WIDTH; the carry is exposed only on cout.
- Reset asserted mid-operation: immediate abort to reset values; the partial result is discarded.
- sum bits for nibbles not yet processed read 0 during RUN. They are not architecturally visible: consumers sample sum only when out_valid=1.

Optional Feature:
- CLA_SUB_EN defined:
  - sub port exists and is latched with the operands.
  - sub=1 latches ~b and forces the effective carry-in to 1 (cin ignored).
  - Result is a-b; cout=1 means no borrow; ovf is signed overflow of the subtraction.
- CLA_SUB_EN undefined: no sub port; addition only.
- Latency is identical in both builds.

Decomposition:
- Shared package cla_pkg holds:
  - localparam CLA_NIB_W=4;
  - FSM state typedef/encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - index width function clog2(WIDTH/4).
- One sub-module: cla_nibble_slice. It is purely combinational and takes 4-bit a/b plus cin; it produces s[3:0], C3, C4, group G and group P. The existing CLA generator may be instantiated inside it for the carry terms.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid high exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through every nibble via the carry reg).
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Complete an op, then hold out_ready=0 for 5 cycles while pulsing in_valid with new operands -> out_valid, sum, cout and ovf unchanged; in_ready=0; the new operands are not accepted.
- After accepting a=0x00FF, b=0x0001, assert rst_n=0 during the 2nd RUN cycle -> outputs return to reset values asynchronously and in_ready=1. A following op with a=0x0002, b=0x0003 then yields sum=0x0005.
- With CLA_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
